div_share_arbiter: RTL

- Shares one serial divider instance (start/done operand interface) between NREQ independent requesters.
- Each requester has a request valid/ready channel (dividend, divisor) and a response valid/ready channel (quotient, remainder, error).
- Round-robin arbitration, one operation in flight, watchdog timeout on the divider.
- Sits between requester logic (Wishbone register front-ends, LA-driven test requesters) and the divider in the user project area.

---
 rtl/div_arb_pkg.sv | 32 +++
 rtl/rr_pick.sv | 37 +++
 rtl/div_share_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the shared-divider arbiter.
// Holds the arbiter FSM encoding, the error result patterns and a helper
// for sizing grant indices.
package div_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Widest supported operand. Result patterns are sliced down to XLEN.
    localparam int RESULT_MAX_W = 64;

    // Quotient reported on timeout or zero-divide: all ones.
    localparam logic [RESULT_MAX_W-1:0] ERR_QUOTIENT = '1;

    // Remainder reported on timeout.
    localparam logic [RESULT_MAX_W-1:0] TMO_REMAINDER = '0;

    // Grant index width for the default two-requester build.
    localparam int NREQ_DEFAULT = 2;
    localparam int GNT_IDX_W    = $clog2(NREQ_DEFAULT);

    // Grant index width for any requester count (at least one bit).
    function automatic int gnt_idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Grants the first set request at or after ptr, scanning upward with wrap.
// The outputs are a one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    // Requester index visited at each scan offset from the pointer.
    logic [IW-1:0] pos [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pos
        assign pos[gi] = (int'(ptr) + gi >= N) ? IW'(int'(ptr) + gi - N)
                                               : IW'(int'(ptr) + gi);
    end

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[pos[i]]) begin
                grant         = '0;
                grant[pos[i]] = 1'b1;
                grant_idx     = pos[i];
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one serial divider between NREQ requesters.
// Round-robin grant, one operation in flight, and a watchdog that forces an
// error response if the divider never completes.
// Optional macro DIV_ARB_ZERO_BYPASS_EN: zero divisors are answered directly
// (quotient all ones, remainder = dividend, error) without using the divider.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int XLEN  = 32,
    parameter int TMO_W = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_dividend_i,
    input  logic [NREQ*XLEN-1:0] req_divisor_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [XLEN-1:0]      rsp_quotient_o,
    output logic [XLEN-1:0]      rsp_remainder_o,
    output logic                 rsp_error_o,
    output logic                 div_start_o,
    output logic [XLEN-1:0]      div_dividend_o,
    output logic [XLEN-1:0]      div_divisor_o,
    input  logic                 div_done_i,
    input  logic [XLEN-1:0]      div_quotient_i,
    input  logic [XLEN-1:0]      div_remainder_i,
    output logic                 busy_o
);

    localparam int IDX_W = gnt_idx_width(NREQ);

    // Last watchdog value before it reaches all ones: the WAIT cycle that
    // times out is the (2**TMO_W-1)th.
    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] gnt_reg, gnt_next;
    logic [XLEN-1:0]  dividend_reg, dividend_next;
    logic [XLEN-1:0]  divisor_reg, divisor_next;
    logic [XLEN-1:0]  quot_reg, quot_next;
    logic [XLEN-1:0]  rem_reg, rem_next;
    logic             err_reg, err_next;
    logic [TMO_W-1:0] wdog_reg, wdog_next;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // Per-requester operand views of the packed buses.
    logic [XLEN-1:0] dividend_arr [NREQ];
    logic [XLEN-1:0] divisor_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign dividend_arr[gi] = req_dividend_i[gi*XLEN +: XLEN];
        assign divisor_arr[gi]  = req_divisor_i[gi*XLEN +: XLEN];
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_pick (
        .req_vec   (req_valid_i),
        .ptr       (ptr_reg),
        .grant     (pick_gnt),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    assign div_dividend_o  = dividend_reg;
    assign div_divisor_o   = divisor_reg;
    assign rsp_quotient_o  = quot_reg;
    assign rsp_remainder_o = rem_reg;
    assign rsp_error_o     = err_reg;
    assign busy_o          = (state_reg != ST_IDLE);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            gnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            err_reg      <= 1'b0;
            wdog_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            quot_reg     <= quot_next;
            rem_reg      <= rem_next;
            err_reg      <= err_next;
            wdog_reg     <= wdog_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        gnt_next      = gnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        quot_next     = quot_reg;
        rem_next      = rem_reg;
        err_next      = err_reg;
        wdog_next     = wdog_reg;
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        div_start_o   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready_o   = pick_gnt;
                    gnt_next      = pick_idx;
                    dividend_next = dividend_arr[pick_idx];
                    divisor_next  = divisor_arr[pick_idx];
                    state_next    = ST_ISSUE;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    if (divisor_arr[pick_idx] == '0) begin
                        quot_next  = ERR_QUOTIENT[XLEN-1:0];
                        rem_next   = dividend_arr[pick_idx];
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                div_start_o = 1'b1;
                wdog_next   = '0;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_next = wdog_reg + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (div_done_i) begin
                    quot_next  = div_quotient_i;
                    rem_next   = div_remainder_i;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (wdog_reg == WDOG_LAST) begin
                    quot_next  = ERR_QUOTIENT[XLEN-1:0];
                    rem_next   = TMO_REMAINDER[XLEN-1:0];
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o[gnt_reg] = 1'b1;
                if (rsp_ready_i[gnt_reg]) begin
                    ptr_next   = (gnt_reg == IDX_W'(NREQ - 1)) ? '0 : gnt_reg + 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
